// File: rtl/fetch_unit_if.sv
// Fetch unit bus: branch redirect, instruction memory req/ack and the
// decode-side instruction/PC handoff. The fetch unit is the master.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             stall;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr_d;
    logic [WIDTH-1:0] pc_d;
    logic             valid_d;
    logic [WIDTH-1:0] pc_next;

    modport master (
        input  br_taken, br_target, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_d, pc_d, valid_d, pc_next
    );

    modport slave (
        output br_taken, br_target, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_d, pc_d, valid_d, pc_next
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch-stage PC generator and instruction requester.
// Holds the architectural PC, issues req/ack instruction reads, applies
// branch redirects from writeback and hands instruction/PC pairs to decode,
// parking one word in a hold buffer while decode stalls.
// Optional macro FETCH_ALIGN_CHECK_EN: adds o_fetch_err, a sticky flag for
// misaligned redirect targets, and forces target bits [1:0] to zero.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      INC      = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic          o_fetch_err,
`endif
    fetch_unit_if.master  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       r_state;
    logic             r_armed;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stale_addr;
    logic [31:0]      r_instr_d;
    logic [WIDTH-1:0] r_pc_d;
    logic             r_valid_d;
    logic [31:0]      r_hold_instr;
    logic [WIDTH-1:0] r_hold_pc;

    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_req;
    logic             w_ack;

`ifdef FETCH_ALIGN_CHECK_EN
    logic             r_fetch_err;
    logic             w_misaligned;

    assign w_target     = {bus.br_target[WIDTH-1:2], 2'b00};
    assign w_misaligned = |bus.br_target[1:0];
    assign o_fetch_err  = r_fetch_err;

    // Sticky flag: set by any misaligned redirect, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_err <= 1'b0;
        end else if (bus.br_taken && w_misaligned) begin
            r_fetch_err <= 1'b1;
        end
    end
`else
    assign w_target = bus.br_target;
`endif

    // PC increment wraps modulo 2^WIDTH by construction
    assign w_pc_inc = r_pc + WIDTH'(INC);
    assign w_req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
    // An ACK outside a request is meaningless and is masked here
    assign w_ack    = w_req && bus.imem_ack;

    // While draining, the request stays on the abandoned address until it completes
    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = (r_state == S_DRAIN) ? r_stale_addr : r_pc;
    assign bus.pc_next    = bus.br_taken ? w_target : w_pc_inc;
    assign bus.instr_d    = r_instr_d;
    assign bus.pc_d       = r_pc_d;
    assign bus.valid_d    = r_valid_d;

    // Fetch FSM, PC, decode register and hold buffer; redirect outranks all but reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_pc         <= RESET_PC;
            r_stale_addr <= RESET_PC;
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_valid_d    <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else if (bus.br_taken) begin
            r_pc      <= w_target;
            r_valid_d <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    // Outstanding read must complete before the new target is requested
                    if (!w_ack) begin
                        r_state      <= S_DRAIN;
                        r_stale_addr <= r_pc;
                    end
                end
                S_DRAIN: r_state <= S_DRAIN;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    // IDLE spans one full clock after reset release before fetching
                    if (r_armed) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_armed <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_pc <= w_pc_inc;
                        if (bus.stall) begin
                            r_hold_instr <= bus.imem_rdata;
                            r_hold_pc    <= r_pc;
                            r_state      <= S_HOLD;
                        end else begin
                            r_instr_d <= bus.imem_rdata;
                            r_pc_d    <= r_pc;
                            r_valid_d <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        r_valid_d <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        r_instr_d <= r_hold_instr;
                        r_pc_d    <= r_hold_pc;
                        r_valid_d <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    // DRAIN: completing data is dropped, PC already holds the target
                    if (!bus.stall) begin
                        r_valid_d <= 1'b0;
                    end
                    if (w_ack) begin
                        r_state <= S_FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory responder with configurable
// latency, a decode-side scoreboard, and one task per scenario.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic clk;
    logic rst_n;
    logic fetch_err;

    int errors = 0;
    int checks = 0;
    int mem_lat = 0;
    logic mem_hold = 1'b0;
    logic drain = 1'b0;
    logic [63:0] sb[$];

    fetch_unit_if #(.WIDTH(32)) bus ();

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .INC(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
`ifdef FETCH_ALIGN_CHECK_EN
        .o_fetch_err (fetch_err),
`endif
        .bus         (bus.master)
    );

`ifndef FETCH_ALIGN_CHECK_EN
    assign fetch_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ACK after mem_lat wait cycles, data = addr ^ K
    initial begin
        int wcnt;
        wcnt = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_rdata = bus.imem_addr ^ K;
            if (bus.imem_req && !mem_hold && wcnt >= mem_lat) begin
                bus.imem_ack = 1'b1;
                wcnt = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wcnt = bus.imem_req ? wcnt + 1 : 0;
            end
        end
    end

    // Scoreboard: push accepted reads, pop on decode consumption, flush on redirect/reset
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                drain = 1'b0;
            end else begin
                if (bus.valid_d && !bus.stall) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: got pc=%h instr=%h, required no valid word", bus.pc_d, bus.instr_d);
                    end else begin
                        exp = sb.pop_front();
                        if ({bus.pc_d, bus.instr_d} !== exp) begin
                            errors++;
                            $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                                     bus.pc_d, bus.instr_d, exp[63:32], exp[31:0]);
                        end
                    end
                end
                if (bus.br_taken) begin
                    sb.delete();
                    if (bus.imem_req && !bus.imem_ack) drain = 1'b1;
                end else if (bus.imem_req && bus.imem_ack) begin
                    if (drain) drain = 1'b0;
                    else sb.push_back({bus.imem_addr, bus.imem_addr ^ K});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        mem_hold = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.imem_req === 1'b1 && bus.imem_addr === a) && n < 60);
        checks++;
        if (!(bus.imem_req === 1'b1 && bus.imem_addr === a)) begin
            errors++;
            $display("FAIL wait_addr: got req=%b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        mem_lat = 0;
        tick();
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", bus.imem_req); end
        checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus.valid_d); end
        checks++; if (bus.pc_d !== 32'h0) begin errors++; $display("FAIL rst_pc_d: got %h required 0", bus.pc_d); end
        checks++; if (bus.instr_d !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h required 0", bus.instr_d); end
        checks++; if (bus.pc_next !== 32'h4) begin errors++; $display("FAIL rst_pc_next: got %h required 4", bus.pc_next); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_fetch_err: got %b required 0", fetch_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL zw_idle_req: got %b required 0", bus.imem_req); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL zw_addr: got req=%b addr=%h required req=1 addr=%h", bus.imem_req, bus.imem_addr, 32'(4 * i));
            end
            checks++;
            if (i == 0) begin
                if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL zw_valid_early: got %b required 0", bus.valid_d); end
            end else if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'(4 * (i - 1)) || bus.instr_d !== (32'(4 * (i - 1)) ^ K)) begin
                errors++;
                $display("FAIL zw_decode: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                         bus.valid_d, bus.pc_d, bus.instr_d, 32'(4 * (i - 1)), 32'(4 * (i - 1)) ^ K);
            end
        end
    endtask

    task automatic test_latency();
        mem_lat = 2;
        do_reset();
        wait_addr(32'h8);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.pc_next !== 32'hC) begin
                errors++;
                $display("FAIL lat_hold: got req=%b addr=%h pc_next=%h required 1 8 c", bus.imem_req, bus.imem_addr, bus.pc_next);
            end
            checks++;
            if (bus.valid_d !== (i == 0) || (i == 0 && bus.pc_d !== 32'h4)) begin
                errors++;
                $display("FAIL lat_pulse: cycle %0d got v=%b pc=%h", i, bus.valid_d, bus.pc_d);
            end
            tick();
        end
        checks++;
        if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h8 || bus.imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL lat_done: got v=%b pc=%h addr=%h required 1 8 c", bus.valid_d, bus.pc_d, bus.imem_addr);
        end
        tick();
        checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL lat_single: got %b required 0", bus.valid_d); end
        mem_lat = 0;
    endtask

    task automatic test_stall();
        mem_lat = 0;
        do_reset();
        wait_addr(32'h10);
        bus.stall = 1'b1;
        checks++; if (bus.pc_d !== 32'hC) begin errors++; $display("FAIL st_prior: got %h required c", bus.pc_d); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b0 || bus.valid_d !== 1'b1 || bus.pc_d !== 32'hC || bus.instr_d !== (32'hC ^ K)) begin
                errors++;
                $display("FAIL st_frozen: got req=%b v=%b pc=%h instr=%h required 0 1 c %h",
                         bus.imem_req, bus.valid_d, bus.pc_d, bus.instr_d, 32'hC ^ K);
            end
            if (i == 1) bus.stall = 1'b1;
        end
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h10 || bus.instr_d !== (32'h10 ^ K) || bus.imem_addr !== 32'h14 || bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL st_release: got v=%b pc=%h instr=%h addr=%h", bus.valid_d, bus.pc_d, bus.instr_d, bus.imem_addr);
        end
        tick();
        checks++; if (bus.pc_d !== 32'h14) begin errors++; $display("FAIL st_next: got %h required 14", bus.pc_d); end
    endtask

    task automatic test_branch_wait();
        mem_lat = 0;
        do_reset();
        wait_addr(32'h20);
        mem_hold = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_target = 32'h100;
        #1;
        checks++; if (bus.pc_next !== 32'h100) begin errors++; $display("FAIL bw_pc_next: got %h required 100", bus.pc_next); end
        tick();
        bus.br_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.valid_d !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin
                errors++;
                $display("FAIL bw_drain: got v=%b req=%b addr=%h required 0 1 20", bus.valid_d, bus.imem_req, bus.imem_addr);
            end
            if (i == 0) tick();
        end
        mem_hold = 1'b0;
        tick();
        checks++;
        if (bus.valid_d !== 1'b0 || bus.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL bw_target: got v=%b addr=%h required 0 100", bus.valid_d, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h100 || bus.instr_d !== (32'h100 ^ K)) begin
            errors++;
            $display("FAIL bw_first: got v=%b pc=%h instr=%h required 1 100 %h", bus.valid_d, bus.pc_d, bus.instr_d, 32'h100 ^ K);
        end
    endtask

    task automatic test_branch_ack_stall();
        mem_lat = 0;
        do_reset();
        wait_addr(32'h10);
        bus.br_taken = 1'b1;
        bus.br_target = 32'h200;
        bus.stall = 1'b1;
        tick();
        bus.br_taken = 1'b0;
        checks++;
        if (bus.valid_d !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL bas_flush: got v=%b req=%b addr=%h required 0 1 200", bus.valid_d, bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.valid_d !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bas_hold: got v=%b req=%b required 0 0", bus.valid_d, bus.imem_req);
        end
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h200 || bus.imem_addr !== 32'h204) begin
            errors++;
            $display("FAIL bas_resume: got v=%b pc=%h addr=%h required 1 200 204", bus.valid_d, bus.pc_d, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        mem_lat = 0;
        do_reset();
        wait_addr(32'h8);
        bus.br_taken = 1'b1;
        bus.br_target = 32'hFFFF_FFF8;
        tick();
        bus.br_taken = 1'b0;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wr_addr0: got %h required fffffff8", bus.imem_addr); end
        tick();
        checks++;
        if (bus.imem_addr !== 32'hFFFF_FFFC || bus.pc_next !== 32'h0) begin
            errors++;
            $display("FAIL wr_addr1: got addr=%h pc_next=%h required fffffffc 0", bus.imem_addr, bus.pc_next);
        end
        tick();
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.pc_d !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wr_addr2: got addr=%h pc_d=%h required 0 fffffffc", bus.imem_addr, bus.pc_d);
        end
    endtask

    task automatic test_async_reset();
        mem_lat = 2;
        do_reset();
        wait_addr(32'h4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.valid_d !== 1'b0 || bus.pc_d !== 32'h0 || bus.instr_d !== 32'h0 || bus.pc_next !== 32'h4) begin
            errors++;
            $display("FAIL ar_async: got req=%b v=%b pc_d=%h instr=%h pc_next=%h required 0 0 0 0 4",
                     bus.imem_req, bus.valid_d, bus.pc_d, bus.instr_d, bus.pc_next);
        end
        tick();
        tick();
        mem_lat = 0;
        rst_n = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ar_idle: got req=%b required 0", bus.imem_req); end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL ar_restart: got req=%b addr=%h required 1 0", bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h0) begin
            errors++;
            $display("FAIL ar_first: got v=%b pc=%h required 1 0", bus.valid_d, bus.pc_d);
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align();
        mem_lat = 0;
        do_reset();
        wait_addr(32'h8);
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL al_clear: got %b required 0", fetch_err); end
        bus.br_taken = 1'b1;
        bus.br_target = 32'h102;
        tick();
        bus.br_taken = 1'b0;
        checks++;
        if (fetch_err !== 1'b1 || bus.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL al_err: got err=%b addr=%h required 1 100", fetch_err, bus.imem_addr);
        end
        tick();
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL al_sticky: got %b required 1", fetch_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_branch_wait();
        test_branch_ack_stall();
        test_wrap();
        test_async_reset();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align();
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
